aes_encipher_block: RTL and testbench
=====================================

# aes_encipher_block

Iterative AES forward cipher datapath that consumes the round keys produced by the key-expansion stage and encrypts one 128-bit block per request. It drives the round index into the key memory, reads back the matching 128-bit round key combinationally, and borrows the shared 32-bit S-box one word per cycle. It sits between the key-expansion stage and the top-level core control. It supports 128-bit and 256-bit keys.

## Interface
Parameters: none. Round counts and key-length codes come from the shared package.
- clk  in  1  clock; all state updates on rising edge.
- reset_n  in  1  synchronous, active-low reset.
- next  in  1  start pulse; sampled only in IDLE.
- keylen  in  1  0 = AES-128 (10 rounds), 1 = AES-256 (14 rounds); latched at start.
- round  out  4  round-key index requested from key expansion; equals the internal round counter.
- round_key  in  128  round key for `round`, valid in the same cycle.
- sboxw  out  32  word sent to the shared S-box.
- new_sboxw  in  32  S-box result for `sboxw`, combinational, same cycle.
- block  in  128  plaintext, sampled on the accepting edge.
- new_block  out  128  ciphertext, valid while ready=1 after completion.
- ready  out  1  high when idle; low while encrypting.

## Operation
- Reset values (reset_n=0 at an edge):
  - state=IDLE, ready=1, round=0, word counter=0.
  - block register = 0, so new_block=0.
  - Reset mid-encryption aborts the operation and applies these values.
- IDLE:
  - On next=1: block_reg <= block ^ round_key (round is 0). Round counter <= 1, keylen latched, ready <= 0, go to SBOX.
  - On next=0: hold. new_block and ready do not change.
- SBOX (4 cycles):
  - sboxw = block_reg word selected by the word counter (0 = bits 127:96, up to 3 = bits 31:0).
  - That word is replaced with new_sboxw, then the word counter increments.
  - After word 3 the counter wraps to 0 and the FSM goes to MAIN.
- MAIN (1 cycle):
  - Non-final round: block_reg <= MixColumns(ShiftRows(block_reg)) ^ round_key. Round counter +1, go to SBOX.
  - Final round (counter == 10 or 14 per the latched keylen): MixColumns is skipped. Round counter <= 0, ready <= 1, go to IDLE.
- sboxw is 0 outside SBOX. The top level gives the S-box to key expansion whenever this block is idle.
- next is ignored while ready=0. keylen changes mid-operation are ignored.
- Arithmetic is byte-wise GF(2^8) with the reduction constant 0x1b. The round counter is 4 bits and never exceeds 14.

## Timing
- Edge E0 accepts next. Round r's MAIN executes at edge E0+5r.
- ready rises after E50 for AES-128 and after E70 for AES-256.
- new_block is valid at the first cycle with ready=1 and holds until the next accept.
- next asserted in the same cycle ready rises is accepted: back-to-back operation with no bubble.
- round_key is read combinationally in IDLE and MAIN, with no pipeline register.

## Structure
- Shared package aes_pkg holds:
  - keylen codes.
  - AES_128_NUM_ROUNDS=10 and AES_256_NUM_ROUNDS=14.
  - The FSM state encoding (IDLE, SBOX, MAIN).
  - Functions gm2, gm3, mixw (one column), and shiftrows.
- One natural sub-module: aes_mixcolumns, a purely combinational 128-bit MixColumns. The same package functions are reused later by the decipher block.

## Test plan
- FIPS-197 C.1: key 000102030405060708090a0b0c0d0e0f, plaintext 00112233445566778899aabbccddeeff, keylen=0 -> new_block 69c4e0d86a7b0430d8cdb78070b4c55a. ready must be low for exactly 50 cycles.
- FIPS-197 C.3: key 000102…1e1f, same plaintext, keylen=1 -> 8ea2b7ca516745bfeafc49904b496089 after 70 cycles. round must step 0,1,…,14,0.
- FIPS-197 App. B: key 2b7e151628aed2a6abf7158809cf4f3c, plaintext 3243f6a8885a308d313198a2e0370734 -> 3925841d02dc09fbdc118597196a0b32. After the first MAIN, block_reg equals a49c7ff2689f352b6b5bea43026a5049.
- Back-to-back: next held high across completion -> a second encryption starts with no idle cycle and both ciphertexts are correct. next pulsed at cycle 20 of an operation has no effect.
- Reset mid-operation: reset_n=0 at cycle 30 -> the next cycle shows ready=1, round=0, new_block=0, sboxw=0. A following C.1 run still gives the correct result.
- keylen toggled from 0 to 1 at cycle 10 of an AES-128 run -> the operation still ends after 10 rounds with the C.1 ciphertext.

Source files
------------

// File: rtl/aes_pkg.sv
// aes_pkg: shared AES definitions for the cipher datapaths.
//   - key-length codes and round counts
//   - round FSM state encoding
//   - GF(2^8) helpers gm2/gm3, one-column MixColumns (mixw), ShiftRows
// Byte/word order: bits 127:96 are column 0, and the top byte of each
// column is row 0.
package aes_pkg;

  localparam logic AES_128_BIT_KEY = 1'b0;
  localparam logic AES_256_BIT_KEY = 1'b1;

  localparam logic [3:0] AES_128_NUM_ROUNDS = 4'd10;
  localparam logic [3:0] AES_256_NUM_ROUNDS = 4'd14;

  typedef enum logic [1:0] {
    CTRL_IDLE = 2'd0,
    CTRL_SBOX = 2'd1,
    CTRL_MAIN = 2'd2
  } aes_ctrl_e;

  // Multiply by x in GF(2^8). Reduction polynomial x^8+x^4+x^3+x+1 (0x1b).
  function automatic logic [7:0] gm2(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (8'h1b & {8{b[7]}});
  endfunction

  function automatic logic [7:0] gm3(input logic [7:0] b);
    return gm2(b) ^ b;
  endfunction

  // MixColumns on a single column {row0, row1, row2, row3}.
  function automatic logic [31:0] mixw(input logic [31:0] w);
    logic [7:0] b0, b1, b2, b3;
    b0 = w[31:24];
    b1 = w[23:16];
    b2 = w[15:8];
    b3 = w[7:0];
    return {gm2(b0) ^ gm3(b1) ^ b2      ^ b3,
            b0      ^ gm2(b1) ^ gm3(b2) ^ b3,
            b0      ^ b1      ^ gm2(b2) ^ gm3(b3),
            gm3(b0) ^ b1      ^ b2      ^ gm2(b3)};
  endfunction

  // Row r is rotated left by r columns: new[col c] takes old[col (c+r)%4].
  function automatic logic [127:0] shiftrows(input logic [127:0] d);
    logic [31:0] w0, w1, w2, w3;
    w0 = d[127:96];
    w1 = d[95:64];
    w2 = d[63:32];
    w3 = d[31:0];
    return {w0[31:24], w1[23:16], w2[15:8], w3[7:0],
            w1[31:24], w2[23:16], w3[15:8], w0[7:0],
            w2[31:24], w3[23:16], w0[15:8], w1[7:0],
            w3[31:24], w0[23:16], w1[15:8], w2[7:0]};
  endfunction

endpackage

// File: rtl/aes_mixcolumns.sv
// aes_mixcolumns: purely combinational MixColumns over a 128-bit state.
//   data_in  [127:0]  state before MixColumns
//   data_out [127:0]  state after MixColumns
module aes_mixcolumns
  import aes_pkg::*;
(
  input  logic [127:0] data_in,
  output logic [127:0] data_out
);

  for (genvar gi = 0; gi < 4; gi++) begin : g_col
    assign data_out[127-32*gi -: 32] = mixw(data_in[127-32*gi -: 32]);
  end

endmodule

// File: rtl/aes_encipher_block.sv
// aes_encipher_block: iterative AES forward cipher (AES-128 / AES-256).
// One round = 4 SBOX cycles (one 32-bit word through the shared S-box per
// cycle) followed by one MAIN cycle (ShiftRows, MixColumns, AddRoundKey).
// Ports:
//   clk, reset_n       clock, synchronous active-low reset
//   next               start pulse, honoured only while idle
//   keylen             0 = AES-128, 1 = AES-256, latched at start
//   round [3:0]        round-key index to the key expansion (= round counter)
//   round_key [127:0]  key for `round`, combinational from key expansion
//   sboxw [31:0]       word to the shared S-box (0 when not in SBOX)
//   new_sboxw [31:0]   S-box result for sboxw, same cycle
//   block [127:0]      plaintext, sampled on the accepting edge
//   new_block [127:0]  ciphertext, valid while ready=1 after a run
//   ready              high while idle
module aes_encipher_block
  import aes_pkg::*;
(
  input  logic         clk,
  input  logic         reset_n,
  input  logic         next,
  input  logic         keylen,
  output logic [3:0]   round,
  input  logic [127:0] round_key,
  output logic [31:0]  sboxw,
  input  logic [31:0]  new_sboxw,
  input  logic [127:0] block,
  output logic [127:0] new_block,
  output logic         ready
);

  aes_ctrl_e        state_q, state_d;
  // Word view of the state: index 3 is bits 127:96 (word counter value 0).
  logic [3:0][31:0] block_q, block_d;
  logic [3:0]       round_q, round_d;
  logic [1:0]       word_q, word_d;
  logic             keylen_q, keylen_d;
  logic             ready_q, ready_d;

  logic [127:0] shifted;
  logic [127:0] mixed;
  logic [3:0]   final_round;

  assign shifted     = shiftrows(block_q);
  assign final_round = keylen_q ? AES_256_NUM_ROUNDS : AES_128_NUM_ROUNDS;

  aes_mixcolumns u_mixcolumns (
    .data_in  (shifted),
    .data_out (mixed)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q  <= CTRL_IDLE;
      block_q  <= '0;
      round_q  <= 4'd0;
      word_q   <= 2'd0;
      keylen_q <= 1'b0;
      ready_q  <= 1'b1;
    end else begin
      state_q  <= state_d;
      block_q  <= block_d;
      round_q  <= round_d;
      word_q   <= word_d;
      keylen_q <= keylen_d;
      ready_q  <= ready_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    block_d  = block_q;
    round_d  = round_q;
    word_d   = word_q;
    keylen_d = keylen_q;
    ready_d  = ready_q;
    sboxw    = 32'h0;

    case (state_q)
      CTRL_IDLE: begin
        if (next) begin
          // round_q is 0 here, so round_key is the initial whitening key.
          block_d  = block ^ round_key;
          round_d  = 4'd1;
          word_d   = 2'd0;
          keylen_d = keylen;
          ready_d  = 1'b0;
          state_d  = CTRL_SBOX;
        end
      end

      CTRL_SBOX: begin
        // ~word_q maps counter 0..3 onto word index 3..0 (MSW first).
        sboxw            = block_q[~word_q];
        block_d[~word_q] = new_sboxw;
        word_d           = word_q + 2'd1;
        if (word_q == 2'd3) begin
          state_d = CTRL_MAIN;
        end
      end

      CTRL_MAIN: begin
        if (round_q == final_round) begin
          block_d = shifted ^ round_key;
          round_d = 4'd0;
          ready_d = 1'b1;
          state_d = CTRL_IDLE;
        end else begin
          block_d = mixed ^ round_key;
          round_d = round_q + 4'd1;
          state_d = CTRL_SBOX;
        end
      end

      default: begin
        state_d = CTRL_IDLE;
      end
    endcase
  end

  assign round     = round_q;
  assign new_block = block_q;
  assign ready     = ready_q;

endmodule

// File: tb/tb_aes_encipher_block.sv
// Testbench for aes_encipher_block. The bench plays the role of the key
// expansion and the shared S-box, and keeps a byte-matrix AES reference.
// Expected ciphertexts go into a queue at start time; a monitor pops and
// compares each time ready rises.
module tb_aes_encipher_block;

  logic         clk;
  logic         reset_n;
  logic         next;
  logic         keylen;
  logic [3:0]   round;
  logic [127:0] round_key;
  logic [31:0]  sboxw;
  logic [31:0]  new_sboxw;
  logic [127:0] block;
  logic [127:0] new_block;
  logic         ready;

  int errors = 0;
  int checks = 0;

  logic [7:0]   sbox_tab [0:255];
  logic [127:0] rk_tab   [0:15];

  typedef struct {
    logic [127:0] ct;
    int           cycles;
  } exp_t;
  exp_t exp_q[$];

  aes_encipher_block dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .next      (next),
    .keylen    (keylen),
    .round     (round),
    .round_key (round_key),
    .sboxw     (sboxw),
    .new_sboxw (new_sboxw),
    .block     (block),
    .new_block (new_block),
    .ready     (ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign round_key = rk_tab[round];
  assign new_sboxw = {sbox_tab[sboxw[31:24]], sbox_tab[sboxw[23:16]],
                      sbox_tab[sboxw[15:8]],  sbox_tab[sboxw[7:0]]};

  // ---------------- reference model ----------------
  function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
    logic [7:0] a, b, p;
    logic       hi;
    a = a_in; b = b_in; p = 8'h0;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      hi = a[7];
      a  = a << 1;
      if (hi) a = a ^ 8'h1b;
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
    return (v << n) | (v >> (8 - n));
  endfunction

  task automatic build_sbox();
    logic [7:0] inv, x8, y8;
    for (int x = 0; x < 256; x++) begin
      x8  = 8'(x);
      inv = 8'h0;
      for (int y = 1; y < 256; y++) begin
        y8 = 8'(y);
        if (gmul(x8, y8) == 8'h01) inv = y8;
      end
      sbox_tab[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3)
                    ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  function automatic logic [31:0] subword(input logic [31:0] w);
    return {sbox_tab[w[31:24]], sbox_tab[w[23:16]], sbox_tab[w[15:8]], sbox_tab[w[7:0]]};
  endfunction

  // 128-bit keys occupy key[255:128].
  task automatic expand(input logic [255:0] key, input bit kl);
    logic [31:0] w [0:59];
    logic [31:0] temp;
    logic [7:0]  rcon;
    int nk, nr;
    nk = kl ? 8 : 4;
    nr = kl ? 14 : 10;
    rcon = 8'h01;
    for (int i = 0; i < 16; i++) rk_tab[i] = '0;
    for (int i = 0; i < nk; i++) w[i] = key[255-32*i -: 32];
    for (int i = nk; i < 4*(nr+1); i++) begin
      temp = w[i-1];
      if (i % nk == 0) begin
        temp = subword({temp[23:0], temp[31:24]}) ^ {rcon, 24'h0};
        rcon = gmul(rcon, 8'h02);
      end else if (nk == 8 && i % nk == 4) begin
        temp = subword(temp);
      end
      w[i] = w[i-nk] ^ temp;
    end
    for (int r = 0; r <= nr; r++) rk_tab[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  // State byte i sits at row i%4, column i/4.
  function automatic logic [127:0] ref_encrypt(input logic [127:0] pt, input int nr);
    logic [7:0] s [0:15];
    logic [7:0] t [0:15];
    logic [7:0] a [0:3];
    logic [127:0] res;
    for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8] ^ rk_tab[0][127-8*i -: 8];
    for (int r = 1; r <= nr; r++) begin
      for (int i = 0; i < 16; i++) s[i] = sbox_tab[s[i]];
      for (int c = 0; c < 4; c++)
        for (int row = 0; row < 4; row++)
          t[row + 4*c] = s[row + 4*((c + row) % 4)];
      for (int c = 0; c < 4; c++) begin
        for (int row = 0; row < 4; row++) a[row] = t[row + 4*c];
        for (int row = 0; row < 4; row++) begin
          if (r < nr)
            s[row + 4*c] = gmul(8'h02, a[row]) ^ gmul(8'h03, a[(row+1)%4])
                           ^ a[(row+2)%4] ^ a[(row+3)%4];
          else
            s[row + 4*c] = a[row];
        end
      end
      for (int i = 0; i < 16; i++) s[i] = s[i] ^ rk_tab[r][127-8*i -: 8];
    end
    for (int i = 0; i < 16; i++) res[127-8*i -: 8] = s[i];
    return res;
  endfunction

  // ---------------- helpers ----------------
  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic start(input logic [127:0] pt, input bit kl, input logic [127:0] exp_ct,
                       input bit hold_next);
    exp_t e;
    e.ct     = exp_ct;
    e.cycles = kl ? 70 : 50;
    exp_q.push_back(e);
    block  = pt;
    keylen = kl;
    next   = 1'b1;
    @(posedge clk); #1;
    if (!hold_next) next = 1'b0;
  endtask

  task automatic wait_ready();
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk); #1;
      if (ready) begin
        seen = 1'b1;
        break;
      end
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL wait_ready: ready still %b after 200 cycles, expected 1", ready);
    end
  endtask

  // ---------------- monitor / scoreboard ----------------
  initial begin
    bit   prev_ready;
    int   low_cnt;
    int   txn;
    exp_t e;
    prev_ready = 1'b1;
    low_cnt    = 0;
    txn        = 0;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        prev_ready = 1'b1;
        low_cnt    = 0;
      end else begin
        if (!ready) begin
          low_cnt++;
        end else if (!prev_ready) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL completion: unexpected result %h with no pending request", new_block);
          end else begin
            e = exp_q.pop_front();
            chk("ciphertext", new_block, e.ct);
            chk("busy_cycles", 128'(low_cnt), 128'(e.cycles));
            $display("txn %0d: ct=%h busy_cycles=%0d", txn, new_block, low_cnt);
          end
          txn++;
          low_cnt = 0;
        end
        prev_ready = ready;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  localparam logic [255:0] KEY_C1 = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
  localparam logic [255:0] KEY_C3 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [255:0] KEY_B  = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
  localparam logic [127:0] PT_C   = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT_C1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] CT_C3  = 128'h8ea2b7ca516745bfeafc49904b496089;
  localparam logic [127:0] PT_B   = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] CT_B   = 128'h3925841d02dc09fbdc118597196a0b32;

  initial begin
    logic [127:0] pt2, ct2, ptr;
    logic [255:0] keyr;
    bit           klr;

    reset_n = 1'b0;
    next    = 1'b0;
    keylen  = 1'b0;
    block   = '0;
    build_sbox();
    for (int i = 0; i < 16; i++) rk_tab[i] = '0;

    repeat (3) @(posedge clk); #1;
    chk("reset_ready", 128'(ready), 128'(1));
    chk("reset_round", 128'(round), 128'(0));
    chk("reset_new_block", new_block, 128'h0);
    chk("reset_sboxw", 128'(sboxw), 128'h0);
    reset_n = 1'b1;

    // FIPS-197 App. B with the state after the first MAIN.
    expand(KEY_B, 1'b0);
    start(PT_B, 1'b0, CT_B, 1'b0);
    repeat (5) @(posedge clk); #1;
    chk("appb_round1", new_block, 128'ha49c7ff2689f352b6b5bea43026a5049);
    wait_ready();

    // C.1 with a stray next pulse at cycle 20.
    expand(KEY_C1, 1'b0);
    chk("ref_model_c1", ref_encrypt(PT_C, 10), CT_C1);
    start(PT_C, 1'b0, CT_C1, 1'b0);
    repeat (19) @(posedge clk); #1;
    next = 1'b1;
    @(posedge clk); #1;
    next = 1'b0;
    wait_ready();

    // C.1 with keylen flipped to 1 at cycle 10.
    start(PT_C, 1'b0, CT_C1, 1'b0);
    repeat (9) @(posedge clk); #1;
    keylen = 1'b1;
    wait_ready();

    // C.3 with the round index stepped through 1..14 then back to 0.
    expand(KEY_C3, 1'b1);
    start(PT_C, 1'b1, CT_C3, 1'b0);
    for (int k = 0; k < 70; k++) begin
      chk("round_seq", 128'(round), 128'(1 + k / 5));
      @(posedge clk); #1;
    end
    chk("round_end", 128'(round), 128'(0));
    wait_ready();

    // Back-to-back: next held across completion.
    expand(KEY_C1, 1'b0);
    pt2 = {$urandom, $urandom, $urandom, $urandom};
    ct2 = ref_encrypt(pt2, 10);
    start(PT_C, 1'b0, CT_C1, 1'b1);
    block = pt2;
    begin
      exp_t e2;
      e2.ct = ct2;
      e2.cycles = 50;
      exp_q.push_back(e2);
    end
    wait_ready();
    @(posedge clk); #1;
    next = 1'b0;
    chk("b2b_no_bubble", 128'(ready), 128'(0));
    wait_ready();

    // Reset at cycle 30 of a C.1 run, then a clean C.1 run.
    start(PT_C, 1'b0, CT_C1, 1'b0);
    repeat (29) @(posedge clk); #1;
    reset_n = 1'b0;
    exp_q.delete();
    @(posedge clk); #1;
    chk("abort_ready", 128'(ready), 128'(1));
    chk("abort_round", 128'(round), 128'(0));
    chk("abort_new_block", new_block, 128'h0);
    chk("abort_sboxw", 128'(sboxw), 128'h0);
    reset_n = 1'b1;
    start(PT_C, 1'b0, CT_C1, 1'b0);
    wait_ready();

    // Random keys, key lengths and plaintexts against the reference.
    for (int n = 0; n < 6; n++) begin
      keyr = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      klr  = 1'($urandom_range(0, 1));
      ptr  = {$urandom, $urandom, $urandom, $urandom};
      expand(keyr, klr);
      start(ptr, klr, ref_encrypt(ptr, klr ? 14 : 10), 1'b0);
      wait_ready();
    end

    begin
      bit drained;
      drained = 1'b0;
      for (int i = 0; i < 10; i++) begin
        @(posedge clk); #1;
        if (exp_q.size() == 0) begin
          drained = 1'b1;
          break;
        end
      end
      checks++;
      if (!drained) begin
        errors++;
        $display("FAIL drain: %0d results outstanding, expected 0", exp_q.size());
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
